branch_resolver: RTL and testbench

//  Parametrised, registered branch-condition unit for the ID-stage branch path.

---
 rtl/branch_resolver.sv | 137 +++++++++++++
 tb/tb_branch_resolver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//   Registered branch-condition unit for the ID-stage branch path. It evaluates
//   a MIPS branch condition on two forwarded operands. The one-bit taken
//   decision is returned through a single-entry valid/ready response buffer.
//   The unit also supports flush, flags illegal conditions, and keeps
//   saturating branch statistics.
//
// Configuration macro:
//   BR_STATS_EN  defined   -> br_cnt / tk_cnt saturating counters are built
//                undefined -> no counter flops, br_cnt / tk_cnt read 0
//
// Ports:
//   clk        system clock, all state changes on posedge
//   reset      synchronous active-high reset (wins over everything)
//   flush      drops the buffered response and blocks new requests this cycle
//   req_valid  request present
//   req_ready  unit can accept a request this cycle (combinational)
//   cond       condition select: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ,
//              5 BGEZ, 6 ALWAYS, 7 illegal
//   op_a       rs operand
//   op_b       rt operand (BEQ/BNE only)
//   rsp_valid  response held in the buffer
//   rsp_ready  consumer takes the response this cycle
//   rsp_taken  branch taken
//   rsp_err    cond was illegal
//   br_cnt     accepted requests
//   tk_cnt     accepted requests that resolved taken
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  logic rsp_valid_reg;
  logic rsp_taken_reg;
  logic rsp_err_reg;
  logic accept;
  logic taken_next;
  logic err_next;
  logic a_neg;
  logic a_zero;

  // The buffer can be refilled in the same cycle its content is consumed.
  // This gives one result per cycle with no bubble.
  assign req_ready = !flush && (!rsp_valid_reg || rsp_ready);
  assign accept    = req_valid && req_ready;

  // The sign bit and a zero test are enough for every compare-against-zero
  // condition. The most negative value has its sign bit set, so it counts as <0.
  assign a_neg  = op_a[WIDTH-1];
  assign a_zero = (op_a == '0);

  always_comb begin
    taken_next = 1'b0;
    err_next   = 1'b0;
    case (cond)
      3'b000:  taken_next = (op_a == op_b);
      3'b001:  taken_next = (op_a != op_b);
      3'b010:  taken_next = a_neg || a_zero;
      3'b011:  taken_next = !a_neg && !a_zero;
      3'b100:  taken_next = a_neg;
      3'b101:  taken_next = !a_neg;
      3'b110:  taken_next = 1'b1;
      default: err_next   = 1'b1;
    endcase
  end

  // Response buffer. Flush has priority over accept and over rsp_ready.
  // taken/err are only written on accept. They therefore hold while the
  // buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_taken_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else if (flush) begin
      rsp_valid_reg <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_taken_reg <= taken_next;
      rsp_err_reg   <= err_next;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_taken = rsp_taken_reg;
  assign rsp_err   = rsp_err_reg;

`ifdef BR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] tk_cnt_reg;

  // Counters depend only on accepts. Flush and backpressure do not affect them.
  // An illegal cond has taken_next=0, so it lands in br_cnt only.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_reg <= '0;
      tk_cnt_reg <= '0;
    end else if (accept) begin
      if (br_cnt_reg != CNT_MAX) begin
        br_cnt_reg <= br_cnt_reg + CNT_ONE;
      end
      if (taken_next && (tk_cnt_reg != CNT_MAX)) begin
        tk_cnt_reg <= tk_cnt_reg + CNT_ONE;
      end
    end
  end

  assign br_cnt = br_cnt_reg;
  assign tk_cnt = tk_cnt_reg;
`else
  assign br_cnt = '0;
  assign tk_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic [2:0]  cond;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_taken, rsp_err;
  logic [15:0] br_cnt, tk_cnt;
  logic        req_ready4, rsp_valid4, rsp_taken4, rsp_err4;
  logic [3:0]  br_cnt4, tk_cnt4;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference state: what the consumer should see after each edge
  logic m_valid, m_taken, m_err;
  int   m_br, m_tk;

  always #5 clk = ~clk;

  branch_resolver #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready), .cond(cond), .op_a(op_a), .op_b(op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_taken(rsp_taken),
    .rsp_err(rsp_err), .br_cnt(br_cnt), .tk_cnt(tk_cnt)
  );

  // Narrow-counter instance driven by the same inputs, used for saturation
  branch_resolver #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready4), .cond(cond), .op_a(op_a), .op_b(op_b),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_taken(rsp_taken4),
    .rsp_err(rsp_err4), .br_cnt(br_cnt4), .tk_cnt(tk_cnt4)
  );

  // Branch decision from the MIPS definitions using signed arithmetic
  function automatic logic ref_taken(input logic [2:0] c, input logic [31:0] a,
                                     input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa <= 0;
      3'd3: return sa > 0;
      3'd4: return sa < 0;
      3'd5: return sa >= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_cnt(input int n, input int w);
`ifdef BR_STATS_EN
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
`else
    return 0 * n * w;
`endif
  endfunction

  function automatic logic exp_ready();
    return !flush && (!m_valid || rsp_ready);
  endfunction

  task automatic drive(input logic fl, input logic rv, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic rr);
    flush = fl; req_valid = rv; cond = c; op_a = a; op_b = b; rsp_ready = rr;
    #1;
  endtask

  // Advance one clock, update the reference, and leave time at edge+1
  task automatic tick();
    logic acc;
    acc = req_valid && exp_ready() && !reset;
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_taken = 0; m_err = 0; m_br = 0; m_tk = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1;
      m_taken = ref_taken(cond, op_a, op_b);
      m_err   = (cond == 3'd7);
      m_br++;
      if (m_taken) m_tk++;
      $display("acc cond=%0d a=%h b=%h -> taken=%0b err=%0b", cond, op_a, op_b, m_taken, m_err);
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_taken !== 1'b0 || rsp_err !== 1'b0) $display("FAIL reset_taken_err got=%b%b exp=00", rsp_taken, rsp_err); else pass_cnt++;
    total_cnt++; if (br_cnt !== 16'd0 || tk_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", br_cnt, tk_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else pass_cnt++;
  endtask

  task automatic test_conds();
    logic [2:0]  tc [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] ta [8] = '{32'd5, 32'd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd77, 32'd3};
    logic [31:0] tb [8] = '{32'd5, 32'd5, 32'd9, 32'd1, 32'd0, 32'd4, 32'd1, 32'd3};
    logic        tt [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, tc[i], ta[i], tb[i], 1);
      tick();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_taken !== tt[i] || rsp_err !== (tc[i] == 3'd7))
        $display("FAIL cond_%0d got v=%b t=%b e=%b exp v=1 t=%b e=%b", tc[i], rsp_valid, rsp_taken, rsp_err, tt[i], tc[i] == 3'd7);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 3'($urandom_range(0, 6)), $urandom, $urandom_range(0, 1) ? op_a : $urandom, 1);
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready_%0d got=%b exp=1", i, req_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_taken !== m_taken)
        $display("FAIL b2b_rsp_%0d got v=%b t=%b exp v=1 t=%b", i, rsp_valid, rsp_taken, m_taken);
      else pass_cnt++;
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (br_cnt !== 16'(exp_cnt(10, 16))) $display("FAIL b2b_br_cnt got=%0d exp=%0d", br_cnt, exp_cnt(10, 16)); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [15:0] br0;
    drive(0, 1, 3'd6, $urandom, $urandom, 0);
    tick();
    br0 = br_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 3'd7, $urandom, $urandom, 0);
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready_%0d got=%b exp=0", i, req_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1 || rsp_err !== 1'b0 || br_cnt !== br0)
        $display("FAIL bp_hold_%0d got v=%b t=%b e=%b br=%0d exp v=1 t=1 e=0 br=%0d", i, rsp_valid, rsp_taken, rsp_err, br_cnt, br0);
      else pass_cnt++;
    end
    drive(0, 0, 0, 0, 0, 1);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_deliver got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [15:0] br0, tk0;
    drive(0, 1, 3'd6, 0, 0, 1);
    tick();
    br0 = br_cnt; tk0 = tk_cnt;
    drive(1, 1, 3'd6, 0, 0, 1);
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL flush_ready got=%b exp=0", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++;
    if (br_cnt !== br0 || tk_cnt !== tk0) $display("FAIL flush_cnt got=%0d/%0d exp=%0d/%0d", br_cnt, tk_cnt, br0, tk0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        3: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 1), 3'($urandom), a,
            $urandom_range(0, 1) ? a : $urandom, $urandom_range(0, 1));
      total_cnt++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready_%0d got=%b exp=%b", i, req_ready, exp_ready()); else pass_cnt++;
      tick();
      total_cnt++;
      if (rsp_valid !== m_valid || rsp_taken !== m_taken || rsp_err !== m_err)
        $display("FAIL rnd_rsp_%0d got v=%b t=%b e=%b exp v=%b t=%b e=%b", i, rsp_valid, rsp_taken, rsp_err, m_valid, m_taken, m_err);
      else pass_cnt++;
      total_cnt++;
      if (br_cnt !== 16'(exp_cnt(m_br, 16)) || tk_cnt !== 16'(exp_cnt(m_tk, 16)))
        $display("FAIL rnd_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, br_cnt, tk_cnt, exp_cnt(m_br, 16), exp_cnt(m_tk, 16));
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 3'd6, $urandom, $urandom, 1);
      tick();
    end
    total_cnt++;
    if (br_cnt4 !== 4'(exp_cnt(20, 4)) || tk_cnt4 !== 4'(exp_cnt(20, 4)))
      $display("FAIL sat_cnt4 got=%0d/%0d exp=%0d/%0d", br_cnt4, tk_cnt4, exp_cnt(20, 4), exp_cnt(20, 4));
    else pass_cnt++;
    total_cnt++;
    if (br_cnt !== 16'(exp_cnt(20, 16)) || tk_cnt !== 16'(exp_cnt(20, 16)))
      $display("FAIL sat_cnt16 got=%0d/%0d exp=%0d/%0d", br_cnt, tk_cnt, exp_cnt(20, 16), exp_cnt(20, 16));
    else pass_cnt++;
    total_cnt++; if (rsp_valid4 !== 1'b1 || rsp_taken4 !== 1'b1) $display("FAIL sat_rsp4 got v=%b t=%b exp 11", rsp_valid4, rsp_taken4); else pass_cnt++;
  endtask

  initial begin
    m_valid = 0; m_taken = 0; m_err = 0; m_br = 0; m_tk = 0;
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_conds();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
